// File: rtl/bitrev_capture_pipe_pkg.sv
// Shared types and the capture-time bit transform for the bitrev capture pipeline.
package bitrev_capture_pkg;

  localparam int unsigned W_MIN     = 1;
  localparam int unsigned W_MAX     = 64;
  localparam int unsigned DEPTH_MIN = 1;
  localparam int unsigned DEPTH_MAX = 8;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_REV    = 2'b01,
    MODE_INV    = 2'b10,
    MODE_REVINV = 2'b11
  } mode_e;

  // Operates on a W_MAX-wide container; only the low w bits are meaningful.
  function automatic logic [W_MAX-1:0] xform(input logic [W_MAX-1:0] a,
                                             input int unsigned      w,
                                             input mode_e            mode);
    logic [W_MAX-1:0] rev;
    rev = {<<{a}};
    rev = rev >> (W_MAX - w);
    unique case (mode)
      MODE_PASS:   xform = a;
      MODE_REV:    xform = rev;
      MODE_INV:    xform = ~a;
      MODE_REVINV: xform = ~rev;
      default:     xform = a;
    endcase
  endfunction

endpackage

// File: rtl/bitrev_capture_pipe_stage.sv
// One valid/data register of the capture pipeline with load and drain control.
module bitrev_pipe_stage #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  input  logic         i_rdy,
  output logic         o_vld,
  output logic [W-1:0] o_d
);

  logic         v_q, v_d;
  logic [W-1:0] d_q, d_d;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (i_load) begin
      v_d = 1'b1;
      d_d = i_d;
    end else if (v_q && i_rdy) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign o_vld = v_q;
  assign o_d   = d_q;

endmodule

// File: rtl/bitrev_capture_pipe.sv
// Strobed capture with selectable bit transform feeding a DEPTH-stage
// valid/ready pipeline, plus delivered/dropped sample counters.
module bitrev_capture_pipe
  import bitrev_capture_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [W-1:0]     i_a,
  input  logic [1:0]       i_mode,
  input  logic             i_rdy,
  output logic             o_vld,
  output logic [W-1:0]     o_a,
  output logic             o_drop,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_drop_cnt
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] load;
  logic [W-1:0]     d   [DEPTH];
  logic [W-1:0]     din [DEPTH];

  logic [W_MAX-1:0] a_ext;
  logic [W_MAX-1:0] xf;
  logic [W-1:0]     cap_d;
  logic             acc0;

  logic             drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    a_ext          = '0;
    a_ext[W-1:0]   = i_a;
    xf             = xform(a_ext, W, mode_e'(i_mode));
    cap_d          = xf[W-1:0];
  end

  assign acc0 = i_en & (~v[0] | rdy[0]);

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    // Unrolled ready chain: a stage may advance if the output is ready or
    // any later stage is empty, which equals the recursive !v[s+1] | rdy[s+1].
    if (s == DEPTH - 1) begin : g_last
      assign rdy[s] = i_rdy;
    end else begin : g_mid
      assign rdy[s] = i_rdy | ~(&v[DEPTH-1:s+1]);
    end

    if (s == 0) begin : g_head
      assign load[s] = acc0;
      assign din[s]  = cap_d;
    end else begin : g_body
      assign load[s] = v[s-1] & rdy[s-1];
      assign din[s]  = d[s-1];
    end

    bitrev_pipe_stage #(
      .W (W)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (load[s]),
      .i_d     (din[s]),
      .i_rdy   (rdy[s]),
      .o_vld   (v[s]),
      .o_d     (d[s])
    );
  end

  always_comb begin
    drop_d     = i_en & ~acc0;
    cnt_d      = cnt_q + CNT_W'(v[DEPTH-1] & i_rdy);
    drop_cnt_d = drop_cnt_q + CNT_W'(drop_d);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop_q     <= 1'b0;
      cnt_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_vld      = v[DEPTH-1];
  assign o_a        = d[DEPTH-1];
  assign o_drop     = drop_q;
  assign o_cnt      = cnt_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bitrev_capture_pipe.sv
// Self-checking bench for bitrev_capture_pipe using a queue-level occupancy model.
module tb_bitrev_capture_pipe;

  localparam int TW = 8;
  localparam int TD = 3;
  localparam int TC = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [TW-1:0] a;
  logic [1:0]    mode;
  logic          rdy;
  logic          vld;
  logic [TW-1:0] oa;
  logic          drop;
  logic [TC-1:0] cnt;
  logic [TC-1:0] dcnt;

  int checks = 0;
  int errors = 0;

  logic [TW-1:0] mq_d[$];
  int            mq_p[$];
  int            exp_cnt;
  int            exp_dcnt;
  logic          exp_drop;

  bitrev_capture_pipe #(
    .W     (TW),
    .DEPTH (TD),
    .CNT_W (TC)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_a        (a),
    .i_mode     (mode),
    .i_rdy      (rdy),
    .o_vld      (vld),
    .o_a        (oa),
    .o_drop     (drop),
    .o_cnt      (cnt),
    .o_drop_cnt (dcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [TW-1:0] ref_xform(input logic [TW-1:0] x, input logic [1:0] m);
    logic [TW-1:0] r;
    for (int i = 0; i < TW; i++) r[i] = m[0] ? x[TW-1-i] : x[i];
    return m[1] ? ~r : r;
  endfunction

  function automatic logic model_vld();
    return (mq_p.size() > 0) && (mq_p[0] == TD - 1);
  endfunction

  task automatic model_reset();
    mq_d.delete();
    mq_p.delete();
    exp_cnt  = 0;
    exp_dcnt = 0;
    exp_drop = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied, then clock the DUT.
  task automatic tick();
    logic acc;
    int   lim;
    int   np;
    acc      = rdy || (mq_d.size() < TD);
    exp_drop = en && !acc;
    if (exp_drop) exp_dcnt = (exp_dcnt + 1) % (1 << TC);
    if (model_vld() && rdy) begin
      void'(mq_d.pop_front());
      void'(mq_p.pop_front());
      exp_cnt = (exp_cnt + 1) % (1 << TC);
    end
    for (int i = 0; i < mq_p.size(); i++) begin
      lim = (i == 0) ? TD - 1 : mq_p[i-1] - 1;
      np  = mq_p[i] + 1;
      mq_p[i] = (np > lim) ? lim : np;
    end
    if (en && acc) begin
      mq_d.push_back(ref_xform(a, mode));
      mq_p.push_back(0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", vld); end
    checks++; if (oa !== '0) begin errors++; $display("FAIL reset_a got %h want 00", oa); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", drop); end
    checks++; if (cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    checks++; if (dcnt !== '0) begin errors++; $display("FAIL reset_dcnt got %0d want 0", dcnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    mode = 2'b01; rdy = 1'b1; en = 1'b1; a = 8'h01;
    tick();
    en = 1'b0; a = 8'($urandom);
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL single_t1_vld got %b want 0", vld); end
    tick();
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL single_t2_vld got %b want 0", vld); end
    tick();
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL single_t3_vld got %b want 1", vld); end
    checks++; if (oa !== 8'h80) begin errors++; $display("FAIL single_t3_a got %h want 80", oa); end
    checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL single_t3_cnt got %0d want 0", cnt); end
    tick();
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL single_t4_vld got %b want 0", vld); end
    checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL single_t4_cnt got %0d want 1", cnt); end
  endtask

  task automatic test_modes();
    logic [TW-1:0] tab [4];
    tab = '{8'hA3, 8'hC5, 8'h5C, 8'h3A};
    rdy = 1'b1;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m); en = 1'b1; a = 8'hA3;
      tick();
      en = 1'b0; mode = 2'($urandom);
      tick();
      tick();
      checks++; if (vld !== 1'b1) begin errors++; $display("FAIL mode%0d_vld got %b want 1", m, vld); end
      checks++; if (oa !== tab[m]) begin errors++; $display("FAIL mode%0d_a got %h want %h", m, oa, tab[m]); end
      tick();
    end
  endtask

  task automatic test_stall_drop();
    logic [TW-1:0] w [5];
    int            base_c;
    int            base_d;
    base_c = exp_cnt;
    base_d = exp_dcnt;
    mode = 2'b00; rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w[i] = 8'($urandom);
      en = 1'b1; a = w[i];
      tick();
      checks++;
      if (drop !== (i >= 3)) begin errors++; $display("FAIL stall_drop%0d got %b want %b", i, drop, (i >= 3)); end
    end
    en = 1'b0;
    tick();
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL stall_drop_end got %b want 0", drop); end
    checks++; if (dcnt !== 4'((base_d + 2) % 16)) begin errors++; $display("FAIL stall_dcnt got %0d want %0d", dcnt, (base_d + 2) % 16); end
    checks++; if (vld !== 1'b1 || oa !== w[0]) begin errors++; $display("FAIL stall_hold1 got %b/%h want 1/%h", vld, oa, w[0]); end
    tick();
    checks++; if (vld !== 1'b1 || oa !== w[0]) begin errors++; $display("FAIL stall_hold2 got %b/%h want 1/%h", vld, oa, w[0]); end
    rdy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i < 3) begin
        checks++;
        if (vld !== 1'b1 || oa !== w[i]) begin errors++; $display("FAIL stall_drain%0d got %b/%h want 1/%h", i, vld, oa, w[i]); end
      end else begin
        checks++;
        if (vld !== 1'b0) begin errors++; $display("FAIL stall_drain_empty got %b want 0", vld); end
      end
    end
    checks++; if (cnt !== 4'((base_c + 3) % 16)) begin errors++; $display("FAIL stall_cnt got %0d want %0d", cnt, (base_c + 3) % 16); end
  endtask

  task automatic test_full_accept();
    logic [TW-1:0] f [4];
    mode = 2'b00; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      f[i] = 8'($urandom); en = 1'b1; a = f[i];
      tick();
    end
    f[3] = 8'($urandom); a = f[3]; rdy = 1'b1;
    tick();
    en = 1'b0;
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL full_accept_drop got %b want 0", drop); end
    checks++; if (vld !== 1'b1 || oa !== f[1]) begin errors++; $display("FAIL full_accept_next got %b/%h want 1/%h", vld, oa, f[1]); end
    tick();
    checks++; if (oa !== f[2]) begin errors++; $display("FAIL full_accept_w2 got %h want %h", oa, f[2]); end
    tick();
    checks++; if (vld !== 1'b1 || oa !== f[3]) begin errors++; $display("FAIL full_accept_w3 got %b/%h want 1/%h", vld, oa, f[3]); end
    tick();
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL full_accept_empty got %b want 0", vld); end
  endtask

  task automatic test_back_to_back();
    mode = 2'b00; rdy = 1'b1;
    for (int j = 0; j < 18; j++) begin
      en = (j < 16); a = 8'(j);
      tick();
      checks++;
      if (drop !== 1'b0) begin errors++; $display("FAIL b2b_drop%0d got %b want 0", j, drop); end
      if (j >= 2) begin
        checks++;
        if (vld !== 1'b1 || oa !== 8'(j - 2)) begin errors++; $display("FAIL b2b_word%0d got %b/%h want 1/%h", j - 2, vld, oa, 8'(j - 2)); end
      end
    end
    en = 1'b0;
    tick();
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", vld); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      en   = ($urandom % 4) != 0;
      rdy  = ($urandom % 3) != 0;
      mode = 2'($urandom);
      a    = 8'($urandom);
      tick();
      checks++;
      if (vld !== model_vld()) begin errors++; $display("FAIL rand%0d_vld got %b want %b", n, vld, model_vld()); end
      if (model_vld()) begin
        checks++;
        if (oa !== mq_d[0]) begin errors++; $display("FAIL rand%0d_a got %h want %h", n, oa, mq_d[0]); end
      end
      checks++;
      if (drop !== exp_drop) begin errors++; $display("FAIL rand%0d_drop got %b want %b", n, drop, exp_drop); end
      checks++;
      if (cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL rand%0d_cnt got %0d want %0d", n, cnt, exp_cnt); end
      checks++;
      if (dcnt !== 4'(exp_dcnt)) begin errors++; $display("FAIL rand%0d_dcnt got %0d want %0d", n, dcnt, exp_dcnt); end
    end
    en = 1'b0; rdy = 1'b1;
    for (int n = 0; n < TD + 1; n++) tick();
  endtask

  task automatic test_reset_mid();
    mode = 2'b00; rdy = 1'b0; en = 1'b1; a = 8'h5A;
    tick();
    en = 1'b0;
    tick();
    tick();
    checks++; if (vld !== 1'b1 || oa !== 8'h5A) begin errors++; $display("FAIL rmid_pre got %b/%h want 1/5a", vld, oa); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL rmid_vld got %b want 0", vld); end
    checks++; if (oa !== '0) begin errors++; $display("FAIL rmid_a got %h want 00", oa); end
    checks++; if (cnt !== '0) begin errors++; $display("FAIL rmid_cnt got %0d want 0", cnt); end
    checks++; if (dcnt !== '0) begin errors++; $display("FAIL rmid_dcnt got %0d want 0", dcnt); end
    en = 1'b1; a = 8'hFF; rdy = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL rmid_en_ignored got %b want 0", vld); end
    en = 1'b0;
    rst_n = 1'b1;
    model_reset();
    tick();
    checks++; if (vld !== 1'b0 || cnt !== '0) begin errors++; $display("FAIL rmid_release got %b/%0d want 0/0", vld, cnt); end
  endtask

  task automatic test_wrap();
    mode = 2'b00; rdy = 1'b1;
    for (int j = 0; j < 16; j++) begin
      en = 1'b1; a = 8'($urandom);
      tick();
    end
    en = 1'b0;
    for (int j = 0; j < TD + 1; j++) tick();
    checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt got %0d want 1", cnt); end
    checks++; if (dcnt !== 4'd0) begin errors++; $display("FAIL wrap_dcnt got %0d want 0", dcnt); end
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; a = '0; mode = 2'b00; rdy = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    test_reset();
    test_single();
    test_modes();
    test_stall_drop();
    test_full_accept();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_single();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
